mem_burst_arbiter: RTL and testbench

- Shares one single-port MEM instance (sync write, combinational read, one address bus) between NUM_REQ requesters in the transaction layer, e.g. RX posted-write sink and TX completion builder.
- Accepts burst requests (start address, length, direction), grants one requester per burst round-robin, and sequences one beat per cycle with auto-incrementing address.
- Read data is returned registered, with valid and last flags.

---
 rtl/mem_burst_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter
// Shares one single-port memory (sync write, combinational read) between
// NUM_REQ burst requesters. One requester is granted per burst; the burst
// then issues one beat per cycle with an auto-incrementing, wrapping address.
// Read beats come back registered one cycle later with valid/last flags.
//
// Optional build macro: MEM_ARB_FIXED_PRIO_EN
//   defined   -> lowest-index valid requester always wins, no RR pointer
//   undefined -> round-robin starting from the requester after the last grant
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no burst; arbitrate, ack the winner and latch its burst fields
// BURST  | one memory beat per cycle until the beat counter reaches 1
module mem_burst_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_REQ-1:0]             wdata_take,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_last,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           busy,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic [DATA_WIDTH-1:0]          mem_data_in,
  output logic                           mem_wr_en,
  input  logic [DATA_WIDTH-1:0]          mem_data_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so the "0 means 2**LEN_WIDTH" length fits in the counter.
  localparam int CNT_W = LEN_WIDTH + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        gnt_q, gnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic                    rsp_last_q, rsp_last_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]        rr_q, rr_d;
`endif

  logic                    arb_found;
  logic [PTR_W-1:0]        arb_win;
  logic [LEN_WIDTH-1:0]    win_len;
  logic [NUM_REQ-1:0]      req_ack_c;
  logic [NUM_REQ-1:0]      wdata_take_c;
  logic                    mem_wr_en_c;
  logic [ADDR_WIDTH-1:0]   mem_address_c;
  logic [DATA_WIDTH-1:0]   mem_data_in_c;

  // Arbitration: first valid requester found scanning upward from the start point.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      if (!arb_found && req_valid[PTR_W'(k)]) begin
        arb_found = 1'b1;
        arb_win   = PTR_W'(k);
      end
`else
      if (!arb_found && req_valid[PTR_W'((int'(rr_q) + k) % NUM_REQ)]) begin
        arb_found = 1'b1;
        arb_win   = PTR_W'((int'(rr_q) + k) % NUM_REQ);
      end
`endif
    end
  end

  assign win_len = req_len[int'(arb_win)*LEN_WIDTH +: LEN_WIDTH];

  // Next-state, burst sequencing and memory-side outputs.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = '0;
    rsp_last_d    = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    req_ack_c     = '0;
    wdata_take_c  = '0;
    mem_wr_en_c   = 1'b0;
    mem_address_c = '0;
    mem_data_in_c = '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_d          = rr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          req_ack_c[arb_win] = 1'b1;
          gnt_d   = arb_win;
          we_d    = req_we[arb_win];
          addr_d  = req_addr[int'(arb_win)*ADDR_WIDTH +: ADDR_WIDTH];
          cnt_d   = (win_len == '0) ? (CNT_W'(1) << LEN_WIDTH) : {1'b0, win_len};
          state_d = S_BURST;
        end
      end

      S_BURST: begin
        mem_address_c = addr_q;
        if (we_q) begin
          mem_wr_en_c           = 1'b1;
          mem_data_in_c         = wdata[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
          wdata_take_c[gnt_q]   = 1'b1;
        end else begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_rdata_d        = mem_data_out;
          rsp_last_d         = (cnt_q == CNT_W'(1));
        end

        addr_d = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
        cnt_d  = cnt_q - CNT_W'(1);

        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr_d = (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, burst context and registered read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  // The ack is decoded from live req_valid, so mask it while reset is held.
  assign req_ack     = rst ? '0 : req_ack_c;
  assign wdata_take  = wdata_take_c;
  assign mem_wr_en   = mem_wr_en_c;
  assign mem_address = mem_address_c;
  assign mem_data_in = mem_data_in_c;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_last    = rsp_last_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = (state_q == S_BURST);

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: a driver issues rounds of burst
// requests and predicts grant order, memory writes and read responses from a
// transaction-level model; a monitor compares whatever the DUT presents.
module tb_mem_burst_arbiter;
  localparam int N     = 2;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LW    = 4;
  localparam int MAXB  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_we, req_ack, wdata_take, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N*DW-1:0]   wdata;
  logic              rsp_last, busy, mem_wr_en;
  logic [DW-1:0]     rsp_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0]     mem_address;

  mem_burst_arbiter #(.NUM_REQ(N), .DEPTH(DEPTH), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_ack(req_ack),
    .wdata(wdata), .wdata_take(wdata_take), .rsp_valid(rsp_valid),
    .rsp_last(rsp_last), .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_wr_en(mem_wr_en), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  typedef struct { int g; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int g; logic [DW-1:0] d; bit last; } rsp_t;

  int   tests = 0;
  int   fails = 0;
  int   run   = 0;
  int   ptr   = 0;
  int   exp_ack [$];
  int   exp_len [$];
  wr_t  exp_wr  [$];
  rsp_t exp_rsp [$];
  logic [DW-1:0] wq [N][$];
  logic [DW-1:0] mem_ram   [DEPTH];
  logic [DW-1:0] mem_model [DEPTH];

  logic          r_we    [N];
  logic [AW-1:0] r_addr  [N];
  logic [LW-1:0] r_len   [N];
  logic [DW-1:0] r_dbase [N];

  assign mem_data_out = mem_ram[mem_address];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic refresh_wdata();
    for (int i = 0; i < N; i++)
      wdata[i*DW +: DW] = (wq[i].size() > 0) ? wq[i][0] : '0;
  endtask

  task automatic flush_model();
    exp_ack.delete(); exp_len.delete(); exp_wr.delete(); exp_rsp.delete();
    for (int i = 0; i < N; i++) wq[i].delete();
    run = 0;
    ptr = 0;
    refresh_wdata();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ack"}, req_ack, 0);
    chk({tag, "_wdata_take"}, wdata_take, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_last"}, rsp_last, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_data_in"}, mem_data_in, 0);
    chk({tag, "_mem_wr_en"}, mem_wr_en, 0);
  endtask

  // Memory behind the DUT: combinational read, write captured mid-cycle and
  // committed at the following rising edge.
  initial begin
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      mem_ram[i]   = 32'hC0DE_0000 + i;
      mem_model[i] = 32'hC0DE_0000 + i;
    end
    forever begin
      @(negedge clk);
      w = mem_wr_en; a = mem_address; d = mem_data_in;
      @(posedge clk);
      if (w) mem_ram[a] = d;
    end
  end

  // Write-data feeder: each requester presents the head of its beat queue and
  // advances after the DUT takes a beat.
  initial begin
    logic [N-1:0] tk;
    forever begin
      @(negedge clk);
      tk = wdata_take;
      @(posedge clk);
      #1;
      if (!rst)
        for (int i = 0; i < N; i++)
          if (tk[i] && wq[i].size() > 0) void'(wq[i].pop_front());
      refresh_wdata();
    end
  end

  // Monitor: compares every DUT-presented event with the scoreboard heads.
  initial begin
    int   e;
    wr_t  w;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy) run++;
        else if (run > 0) begin
          if (exp_len.size() == 0) chk("busy_unexpected", run, 0);
          else chk("busy_len", run, exp_len.pop_front());
          if (exp_ack.size() > 0) chk("ack_after_last_beat", req_ack != 0, 1);
          run = 0;
        end
        if (req_ack != 0) begin
          if (exp_ack.size() == 0) chk("ack_unexpected", req_ack, 0);
          else begin
            e = exp_ack.pop_front();
            chk("ack_idx", req_ack, 1 << e);
            chk("ack_while_busy", busy, 0);
          end
        end
        if (mem_wr_en) begin
          if (exp_wr.size() == 0) chk("wr_unexpected", mem_wr_en, 0);
          else begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_address, w.a);
            chk("wr_data", mem_data_in, w.d);
            chk("wr_take", wdata_take, 1 << w.g);
          end
        end
        if (rsp_valid != 0) begin
          if (exp_rsp.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
          else begin
            r = exp_rsp.pop_front();
            chk("rsp_valid", rsp_valid, 1 << r.g);
            chk("rsp_rdata", rsp_rdata, r.d);
            chk("rsp_last", rsp_last, r.last);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int cyc = 0;
    while ((exp_ack.size() > 0 || exp_wr.size() > 0 || exp_rsp.size() > 0 ||
            exp_len.size() > 0 || busy) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_timeout", cyc < 300, 1);
    if (cyc >= 300) flush_model();
    @(posedge clk);
    #1;
  endtask

  // Model a round in which every requester in mask raises a request at once:
  // grants follow arbitration order, each burst is fully sequenced before the
  // next, and each requester drops its request after being acked.
  task automatic run_round(input logic [N-1:0] mask);
    int i, beats, a, last, cyc, start;
    wr_t  w;
    rsp_t r;
    logic [N-1:0] acked;
`ifdef MEM_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    last = 0;
    for (int k = 0; k < N; k++) begin
      i = (start + k) % N;
      if (mask[i]) begin
        beats = (r_len[i] == 0) ? MAXB : int'(r_len[i]);
        exp_ack.push_back(i);
        exp_len.push_back(beats);
        for (int b = 0; b < beats; b++) begin
          a = (int'(r_addr[i]) + b) % DEPTH;
          if (r_we[i]) begin
            w.g = i; w.a = AW'(a); w.d = r_dbase[i] + b;
            mem_model[a] = w.d;
            wq[i].push_back(w.d);
            exp_wr.push_back(w);
          end else begin
            r.g = i; r.d = mem_model[a]; r.last = (b == beats - 1);
            exp_rsp.push_back(r);
          end
        end
        last = i;
      end
    end
`ifndef MEM_ARB_FIXED_PRIO_EN
    ptr = (last + 1) % N;
`endif
    for (int j = 0; j < N; j++) begin
      req_we[j]           = r_we[j];
      req_addr[j*AW +: AW] = r_addr[j];
      req_len[j*LW +: LW]  = r_len[j];
    end
    refresh_wdata();
    req_valid = mask;
    acked = '0;
    cyc = 0;
    while ((acked & mask) != mask && cyc < 400) begin
      @(negedge clk);
      acked |= req_ack;
      @(posedge clk);
      #1;
      req_valid &= ~acked;
      cyc++;
    end
    chk("ack_timeout", acked & mask, mask);
    req_valid = '0;
    wait_idle();
  endtask

  task automatic set_req(input int i, input logic we, input int addr, input int len, input logic [DW-1:0] db);
    r_we[i] = we; r_addr[i] = AW'(addr); r_len[i] = LW'(len); r_dbase[i] = db;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; wdata = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 1, '0);
    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // single write then read-back
    set_req(0, 1'b1, 5, 3, 32'hA0);
    run_round(2'b01);
    set_req(0, 1'b0, 5, 3, 0);
    run_round(2'b01);

    // address wrap and maximum length
    set_req(0, 1'b1, 30, 4, 32'h5500);
    run_round(2'b01);
    set_req(1, 1'b1, 3, 0, 32'h7700);
    run_round(2'b10);
    set_req(1, 1'b0, 28, 0, 0);
    run_round(2'b10);

    // contention, single beats
    for (int n = 0; n < 3; n++) begin
      set_req(0, 1'b1, 8 + n, 1, 32'h100 * n);
      set_req(1, 1'b0, 8 + n, 1, 0);
      run_round(2'b11);
    end

    // back-to-back: second request granted right after the first 2-beat burst
    set_req(0, 1'b1, 12, 2, 32'hBB00);
    set_req(1, 1'b0, 12, 2, 0);
    run_round(2'b11);

    // reset mid-burst: leave the RR pointer on requester 1 first
    set_req(0, 1'b0, 0, 1, 0);
    run_round(2'b01);
    set_req(1, 1'b0, 10, 8, 0);
    req_we[1] = 1'b0; req_addr[AW +: AW] = 5'd10; req_len[LW +: LW] = 4'd8;
    exp_ack.push_back(1);
    req_valid = 2'b10;
    cyc = 0;
    while (req_ack[1] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_test_ack", req_ack[1], 1);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #3 rst = 1'b1;
    req_valid = 2'b11;
    #1;
    check_outputs_zero("midburst_rst");
    flush_model();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 10, 2, 0);
    set_req(1, 1'b1, 20, 3, 32'hDD00);
    run_round(2'b11);

    // randomized rounds
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom % 2), int'($urandom % DEPTH), int'($urandom % MAXB), $urandom);
      run_round(N'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
